main_fsm: RTL
=============

# main_fsm

Multicycle main controller for the ARM-subset processor. It sequences the shared datapath (one memory, one ALU) through fetch, decode, execute, memory and writeback states, driving the mux selects and write strobes. It waits on a memory ready handshake and halts on unsupported opcodes or memory timeout. It sits beside the instruction decoder (ALU control, flag-write and PC-select logic), which consumes its `ALUOp`, `Branch` and `RegW` outputs.

## Interface
- `MEM_TIMEOUT`, default 255: maximum consecutive cycles spent waiting for `MemReady` in any memory state; 0 disables the timeout.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `Op`  in  2  instruction bits [27:26], taken from the instruction register.
- `Funct`  in  6  instruction bits [25:20], taken from the instruction register.
- `MemReady`  in  1  memory completes the current access this cycle.
- `IRWrite`  out  1  load the instruction register.
- `NextPC`  out  1  write PC+4 to the PC.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `ALUSrcA`  out  1  0 = register A, 1 = PC.
- `ALUSrcB`  out  2  00 = register, 01 = extended immediate, 10 = constant 4.
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALU result.
- `RegW`  out  1  register-file write request.
- `MemW`  out  1  memory write strobe.
- `Branch`  out  1  branch state; PC is loaded from the result.
- `ALUOp`  out  1  the decoder produces ALU control from `Funct`; 0 means add.
- `Halted`  out  1  the controller is in HALT.
- `Timeout`  out  1  sticky; HALT was entered through the memory timeout.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, HALT.
- Outputs not listed for a state are 0.
- **FETCH**
  - Drives `AdrSrc`=0, `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10.
  - `IRWrite` and `NextPC` equal `MemReady` (Mealy).
  - Moves to DECODE when `MemReady`=1; otherwise stays.
- **DECODE**
  - Drives `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10.
  - `Op`=01 goes to MEMADR.
  - `Op`=00 with `Funct[5]`=0 goes to EXECR.
  - `Op`=00 with `Funct[5]`=1 goes to EXECI.
  - `Op`=10 goes to BRANCH.
  - `Op`=11 goes to HALT.
- **MEMADR**
  - Drives `ALUSrcA`=0, `ALUSrcB`=01.
  - `Funct[0]`=1 (LDR) goes to MEMREAD; otherwise (STR) goes to MEMWRITE.
- **MEMREAD**
  - Drives `AdrSrc`=1, `ResultSrc`=00.
  - Moves to MEMWB when `MemReady`=1.
- **MEMWB**
  - Drives `ResultSrc`=01, `RegW`=1.
  - Moves to FETCH.
- **MEMWRITE**
  - Drives `AdrSrc`=1, `ResultSrc`=00.
  - `MemW`=1 for every cycle spent in the state.
  - Moves to FETCH when `MemReady`=1.
- **EXECR**
  - Drives `ALUSrcA`=0, `ALUSrcB`=00, `ALUOp`=1.
  - Moves to ALUWB.
- **EXECI**
  - Drives `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=1.
  - Moves to ALUWB.
- **ALUWB**
  - Drives `ResultSrc`=00, `RegW`=1.
  - Moves to FETCH.
- **BRANCH**
  - Drives `ALUSrcA`=0, `ALUSrcB`=01, `ResultSrc`=10, `Branch`=1.
  - Moves to FETCH.
- **HALT**
  - All strobes are 0 and `Halted`=1.
  - Only `reset` leaves this state.
- **Wait counter**
  - Width is $clog2(`MEM_TIMEOUT`+1).
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE, and whenever `MemReady`=1.
  - Increments on each cycle in one of those states with `MemReady`=0.
  - When the counter equals `MEM_TIMEOUT` and `MemReady`=0, the next state is HALT and `Timeout` is set.
  - If `MemReady`=1 on that same cycle, the access completes normally and no timeout occurs.
  - Saturates and never wraps.

## Timing
- Reset: on the first `clk` edge with `reset`=1, the state goes to FETCH and the counter and `Timeout` clear.
- While `reset`=1, `IRWrite`, `NextPC`, `RegW`, `MemW` and `Branch` are forced to 0. Select outputs show the FETCH values.
- Reset asserted mid-instruction abandons the instruction. No strobe fires on the reset cycle.
- Cycles per instruction with `MemReady` held at 1:
  - branch: 3
  - data processing: 4
  - STR: 4
  - LDR: 5
- Each cycle `MemReady` is low in a memory state adds exactly 1 cycle.
- `Op` and `Funct` are sampled only in DECODE and MEMADR. They must be stable from the cycle after `IRWrite` until the next FETCH.

## Structure
- Package `controller_pkg` holds:
  - the `state_t` enum;
  - named constants for the `ALUSrcB` codes (`SRCB_REG`, `SRCB_IMM`, `SRCB_FOUR`);
  - named constants for the `ResultSrc` codes (`RES_ALUOUT`, `RES_DATA`, `RES_ALU`).
- Sub-module `mem_wait_timer` contains the saturating counter, with `clear`, `inc` and `expired` ports and parameter `MEM_TIMEOUT`.
- Next-state and output decode are separate `always_comb` blocks.

## Test plan
- ADD register form (`Op`=00, `Funct`=001000), `MemReady`=1 → states FETCH, DECODE, EXECR, ALUWB, FETCH. `RegW`=1 only in cycle 4, with `ALUOp`=1 in cycle 3.
- LDR (`Op`=01, `Funct`=011001), `MemReady` low for 2 cycles in MEMREAD → 7 cycles total. `AdrSrc`=1 in MEMREAD, then `ResultSrc`=01 with `RegW`=1 in MEMWB.
- STR (`Funct`=011000) with `MemReady`=1 → `MemW`=1 for exactly 1 cycle, then return to FETCH. A branch (`Op`=10) → `Branch`=1 for 1 cycle; 3 cycles total.
- `Op`=11 → HALT after DECODE with `Halted`=1. No strobes afterward; `reset` returns the controller to FETCH.
- `MEM_TIMEOUT`=3 with `MemReady` stuck at 0 in FETCH → HALT after 4 cycles with `Timeout`=1. Repeat with `MemReady`=1 on the 4th cycle → no timeout.
- `reset` asserted during MEMWRITE while `MemW`=1 → `MemW`=0 in the same cycle and state FETCH on the next edge.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared types and select codes for the
// multicycle ARM-subset main controller.
package controller_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH,
    HALT
  } state_t;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating count of consecutive cycles
// spent waiting for memory ready.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int W =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment; hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register; clear doubles as reset.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign expired = (MEM_TIMEOUT != 0) &&
                   (cnt_q == LIMIT);

endmodule

// File: rtl/main_fsm.sv
// Multicycle main controller: sequences the
// shared datapath and watches memory waits.
module main_fsm
  import controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       Halted,
  output logic       Timeout
);

  state_t state_q;
  state_t state_d;
  state_t out_st;
  logic   timeout_q;
  logic   timeout_d;
  logic   wait_st;
  logic   expired;
  logic   tmo_hit;
  logic   unused_funct;

  assign unused_funct = ^Funct[4:1];

  assign wait_st = (state_q == FETCH) ||
                   (state_q == MEMREAD) ||
                   (state_q == MEMWRITE);

  assign tmo_hit = wait_st & ~MemReady & expired;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .clear  (reset | MemReady | ~wait_st),
    .inc    (wait_st & ~MemReady),
    .expired(expired)
  );

  // Next-state selection per instruction class.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q | tmo_hit;
    unique case (state_q)
      FETCH: begin
        if (tmo_hit)       state_d = HALT;
        else if (MemReady) state_d = DECODE;
      end
      DECODE: begin
        unique case (Op)
          2'b00:
            state_d = Funct[5] ? EXECI : EXECR;
          2'b01: state_d = MEMADR;
          2'b10: state_d = BRANCH;
          default: state_d = HALT;
        endcase
      end
      MEMADR:
        state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD: begin
        if (tmo_hit)       state_d = HALT;
        else if (MemReady) state_d = MEMWB;
      end
      MEMWB:  state_d = FETCH;
      MEMWRITE: begin
        if (tmo_hit)       state_d = HALT;
        else if (MemReady) state_d = FETCH;
      end
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // State and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  assign out_st = reset ? FETCH : state_q;

  // Datapath controls; reset shows FETCH quietly.
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    Halted    = 1'b0;
    unique case (out_st)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = MemReady & ~reset;
        NextPC    = MemReady & ~reset;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      MEMADR: ALUSrcB = SRCB_IMM;
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR: ALUOp = 1'b1;
      EXECI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      ALUWB: RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        Branch    = 1'b1;
      end
      HALT: Halted = 1'b1;
      default: Halted = 1'b1;
    endcase
  end

  assign Timeout = timeout_q;

endmodule
